score_text_renderer: RTL

// Draws the "SCORE:" label plus a 5-digit decimal score as a 1-bit pixel mask for the VGA colour mapper.

---
 rtl/score_pkg.sv | 35 +++
 rtl/score_bcd_converter.sv | 74 +++++++
 rtl/score_text_renderer.sv | 96 +++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and geometry for the score text overlay: glyph sizes, string
// layout and the BCD digit helper used by the renderer.
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int LABEL_LEN  = 6;
  localparam int NUM_DIGITS = 5;
  localparam int SCORE_W    = 16;
  localparam int BCD_W      = NUM_DIGITS * 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Digit 0 is the most significant digit on screen.
  function automatic bcd_digit_t digit_at(input logic [BCD_W-1:0] bcd,
                                          input logic [3:0] idx);
    bcd_digit_t d;
    case (idx)
      4'd0:    d = bcd[19:16];
      4'd1:    d = bcd[15:12];
      4'd2:    d = bcd[11:8];
      4'd3:    d = bcd[7:4];
      4'd4:    d = bcd[3:0];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/score_bcd_converter.sv
// Serial double-dabble binary-to-BCD converter, started once per frame; the
// published digits only change when a conversion has fully finished.
module score_bcd_converter
  import score_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd_out
);

  conv_state_t state, next_state;

  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [3:0]         count;

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (count == 4'd15) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Add-3 correction ahead of each shift keeps every nibble a valid decimal digit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bin_sr  <= '0;
      bcd_sr  <= '0;
      count   <= '0;
      bcd_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin;
            bcd_sr <= '0;
            count  <= '0;
          end
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj, bin_sr} << 1;
          count            <= count + 4'd1;
        end
        DONE:    bcd_out <= bcd_sr;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/score_text_renderer.sv
// Renders "SCORE:" plus five decimal digits as a 1-bit pixel mask, driving the
// label and digit glyph ROMs through a fixed two-stage pixel pipeline.
module score_text_renderer
  import score_pkg::*;
#(
  parameter logic [9:0] TEXT_X = 10'd8,
  parameter logic [9:0] TEXT_Y = 10'd8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [7:0]         label_rom_addr,
  input  logic [7:0]         label_rom_data,
  output logic [7:0]         digit_rom_addr,
  input  logic [7:0]         digit_rom_data,
  output logic               text_pixel_on,
  output logic               busy
);

  localparam int         TEXT_W = (LABEL_LEN + NUM_DIGITS) * GLYPH_W;
  localparam logic [9:0] X_END  = TEXT_X + 10'(TEXT_W);
  localparam logic [9:0] Y_END  = TEXT_Y + 10'(GLYPH_H);

  logic [BCD_W-1:0] bcd_out;
  logic [6:0]       dx;
  logic [3:0]       ch;
  logic [2:0]       col;
  logic [3:0]       row;
  logic             in_region;
  logic             is_label;
  bcd_digit_t       digit;
  logic [7:0]       label_addr_d;
  logic [7:0]       digit_addr_d;

  logic [2:0]       col_q;
  logic             label_sel_q;
  logic             in_region_q;
  logic [7:0]       sel_data;

  score_bcd_converter u_bcd (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (frame_start),
    .bin    (score),
    .busy   (busy),
    .bcd_out(bcd_out)
  );

  // The region test guards the truncated offsets, so wrap below the origin is harmless.
  always_comb begin
    dx           = 7'(DrawX - TEXT_X);
    row          = 4'(DrawY - TEXT_Y);
    ch           = dx[6:3];
    col          = dx[2:0];
    in_region    = (DrawX >= TEXT_X) && (DrawX < X_END) &&
                   (DrawY >= TEXT_Y) && (DrawY < Y_END);
    is_label     = (ch < 4'(LABEL_LEN));
    digit        = digit_at(bcd_out, ch - 4'(LABEL_LEN));
    label_addr_d = '0;
    digit_addr_d = '0;
    if (in_region) begin
      if (is_label) label_addr_d = {ch, row};
      else          digit_addr_d = {digit, row};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      label_rom_addr <= '0;
      digit_rom_addr <= '0;
      col_q          <= '0;
      label_sel_q    <= 1'b0;
      in_region_q    <= 1'b0;
    end else begin
      label_rom_addr <= label_addr_d;
      digit_rom_addr <= digit_addr_d;
      col_q          <= col;
      label_sel_q    <= is_label;
      in_region_q    <= in_region;
    end
  end

  always_comb begin
    sel_data = label_sel_q ? label_rom_data : digit_rom_data;
  end

  // Bit 7 of a glyph row is the leftmost pixel.
  always_ff @(posedge Clk) begin
    if (Reset) text_pixel_on <= 1'b0;
    else       text_pixel_on <= in_region_q & sel_data[3'd7 - col_q];
  end

endmodule
